// File: rtl/fft_post_pkg.sv
// Shared definitions for the FFT post-processing blocks: FSM state
// encoding and the fixed-point phase format.
package fft_post_pkg;

  localparam int PHASE_W    = 32;
  localparam int PHASE_FRAC = 28;

  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_RUN      = 1'b1
  } pd_state_e;

endpackage

// File: rtl/peak_detect.sv
// Per-frame peak search over a bin window of an FFT magnitude stream;
// reports bin index, magnitude and phase of the largest bin once per frame.
module peak_detect
  import fft_post_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NFFT      = 1024,
  parameter int BIN_FIRST = 1,
  parameter int BIN_LAST  = NFFT/2-1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_vld,
  input  logic                      i_sof,
  input  logic signed [WIDTH-1:0]   i_mag,
  input  logic signed [PHASE_W-1:0] i_phase,
  output logic                      o_vld,
  output logic [$clog2(NFFT)-1:0]   o_bin,
  output logic signed [WIDTH-1:0]   o_mag,
  output logic signed [PHASE_W-1:0] o_phase,
  output logic                      o_frame_err
);

  localparam int BW = $clog2(NFFT);
  localparam logic [BW-1:0] FIRST_B = BW'(BIN_FIRST);
  localparam logic [BW-1:0] LAST_B  = BW'(BIN_LAST);
  localparam logic [BW-1:0] END_B   = BW'(NFFT-1);
  localparam logic [BW-1:0] ONE_B   = BW'(1);

  // Negative magnitudes rank as zero; the stored value stays raw.
  function automatic logic [WIDTH-1:0] clamp_mag(input logic signed [WIDTH-1:0] m);
    logic [WIDTH-1:0] r;
    if (m[WIDTH-1]) begin
      r = {WIDTH{1'b0}};
    end else begin
      r = m;
    end
    return r;
  endfunction

  pd_state_e                 state_q, state_d;
  logic [BW-1:0]             cnt_q, cnt_d;
  logic                      have_q, have_d;
  logic [BW-1:0]             best_bin_q, best_bin_d;
  logic signed [WIDTH-1:0]   best_mag_q, best_mag_d;
  logic signed [PHASE_W-1:0] best_ph_q, best_ph_d;
  logic                      o_vld_q, o_vld_d;
  logic                      o_err_q, o_err_d;
  logic [BW-1:0]             o_bin_q, o_bin_d;
  logic signed [WIDTH-1:0]   o_mag_q, o_mag_d;
  logic signed [PHASE_W-1:0] o_ph_q, o_ph_d;

  logic          run_s, acc_s, early_s, fresh_s, cand_s, take_s, last_s, have_eff_s;
  logic [BW-1:0] bin_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_SOF;
      cnt_q      <= {BW{1'b0}};
      have_q     <= 1'b0;
      best_bin_q <= {BW{1'b0}};
      best_mag_q <= {WIDTH{1'b0}};
      best_ph_q  <= {PHASE_W{1'b0}};
      o_vld_q    <= 1'b0;
      o_err_q    <= 1'b0;
      o_bin_q    <= {BW{1'b0}};
      o_mag_q    <= {WIDTH{1'b0}};
      o_ph_q     <= {PHASE_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      have_q     <= have_d;
      best_bin_q <= best_bin_d;
      best_mag_q <= best_mag_d;
      best_ph_q  <= best_ph_d;
      o_vld_q    <= o_vld_d;
      o_err_q    <= o_err_d;
      o_bin_q    <= o_bin_d;
      o_mag_q    <= o_mag_d;
      o_ph_q     <= o_ph_d;
    end
  end

  always_comb begin
    run_s = 1'b0;
    case (state_q)
      ST_RUN:      run_s = 1'b1;
      ST_WAIT_SOF: run_s = 1'b0;
      default:     run_s = 1'b0;
    endcase
  end

  // An i_sof sample always restarts a frame at bin 0.
  assign acc_s      = i_vld && (run_s || i_sof);
  assign early_s    = acc_s && run_s && i_sof && (cnt_q != {BW{1'b0}});
  assign bin_s      = i_sof ? {BW{1'b0}} : cnt_q;
  assign fresh_s    = (bin_s == {BW{1'b0}});
  assign have_eff_s = fresh_s ? 1'b0 : have_q;
  assign cand_s     = (bin_s >= FIRST_B) && (bin_s <= LAST_B);
  assign take_s     = cand_s && (!have_eff_s || (clamp_mag(i_mag) > clamp_mag(best_mag_q)));
  assign last_s     = (bin_s == END_B);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    have_d     = have_q;
    best_bin_d = best_bin_q;
    best_mag_d = best_mag_q;
    best_ph_d  = best_ph_q;
    o_vld_d    = 1'b0;
    o_err_d    = early_s;
    o_bin_d    = o_bin_q;
    o_mag_d    = o_mag_q;
    o_ph_d     = o_ph_q;
    if (acc_s) begin
      state_d = ST_RUN;
      cnt_d   = bin_s + ONE_B;
      have_d  = have_eff_s | cand_s;
      if (take_s) begin
        best_bin_d = bin_s;
        best_mag_d = i_mag;
        best_ph_d  = i_phase;
      end else begin
        best_bin_d = best_bin_q;
      end
      // Publish from the bypass so the final bin is included.
      if (last_s) begin
        o_vld_d = 1'b1;
        o_bin_d = take_s ? bin_s   : best_bin_q;
        o_mag_d = take_s ? i_mag   : best_mag_q;
        o_ph_d  = take_s ? i_phase : best_ph_q;
      end else begin
        o_vld_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  assign o_vld       = o_vld_q;
  assign o_frame_err = o_err_q;
  assign o_bin       = o_bin_q;
  assign o_mag       = o_mag_q;
  assign o_phase     = o_ph_q;

endmodule
